// File: rtl/sdram_pattern_tester.sv
// SDRAM built-in self test: writes a selectable pattern over an address range through the
// controller command port, reads it back, counts mismatches and captures the first failure.
//
// state  | meaning
// IDLE   | waiting for start
// WR_CMD | write command held, counting write beats of one burst
// WR_GAP | one idle cycle between write bursts
// RD_CMD | read command held, comparing read beats of one burst
// RD_GAP | one idle cycle between read bursts
// DONE   | run finished, results held until next start
module sdram_pattern_tester #(
    parameter int ADDR_WIDTH    = 22,
    parameter int DATA_WIDTH    = 16,
    parameter int BURST_LENGTH  = 1,
    parameter int STOP_ON_ERROR = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [1:0]            pattern,
    input  logic [ADDR_WIDTH-1:0] addr_first,
    input  logic [ADDR_WIDTH-1:0] addr_last,
    output logic [1:0]            command,
    output logic [ADDR_WIDTH-1:0] data_address,
    output logic [DATA_WIDTH-1:0] data_write,
    input  logic [DATA_WIDTH-1:0] data_read,
    input  logic                  data_read_valid,
    input  logic                  data_write_done,
    output logic                  busy,
    output logic                  done,
    output logic                  config_error,
    output logic [31:0]           error_count,
    output logic [ADDR_WIDTH-1:0] fail_address,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual
);

    localparam logic [15:0]           LFSR_SEED  = 16'hACE1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] BURST_MASK = ADDR_WIDTH'(BURST_LENGTH - 1);
    localparam logic [3:0]            BEAT_LOAD  = 4'(BURST_LENGTH - 1);
    localparam int                    LREP       = (DATA_WIDTH + 15) / 16;
    localparam int                    CREP       = (DATA_WIDTH + 1) / 2;
    localparam logic [2*CREP-1:0]     CHK_REP    = {CREP{2'b10}};
    localparam logic [DATA_WIDTH-1:0] CHK_EVEN   = CHK_REP[DATA_WIDTH-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_GAP,
        S_RD_CMD,
        S_RD_GAP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   first_q, first_d;
    logic [ADDR_WIDTH-1:0]   last_q, last_d;
    logic [1:0]              pattern_q, pattern_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [3:0]              beat_q, beat_d;
    logic                    end_q, end_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [31:0]             err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0]   fail_act_q, fail_act_d;

    logic [DATA_WIDTH-1:0]   pat_addr;
    logic [DATA_WIDTH-1:0]   pat_lfsr;
    logic [DATA_WIDTH-1:0]   pat_value;
    logic [16*LREP-1:0]      lfsr_rep;
    logic [15:0]             lfsr_next;
    logic                    cfg_bad;
    logic                    mismatch;
    logic [31:0]             err_inc;

    generate
        if (ADDR_WIDTH >= DATA_WIDTH) begin : g_addr_trunc
            assign pat_addr = addr_q[DATA_WIDTH-1:0];
        end else begin : g_addr_ext
            assign pat_addr = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, addr_q};
        end
    endgenerate

    assign lfsr_rep  = {LREP{lfsr_q}};
    assign pat_lfsr  = lfsr_rep[DATA_WIDTH-1:0];
    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_comb begin
        pat_value = pat_addr;
        case (pattern_q)
            2'd0:    pat_value = pat_addr;
            2'd1:    pat_value = ~pat_addr;
            2'd2:    pat_value = pat_lfsr;
            default: pat_value = CHK_EVEN ^ {DATA_WIDTH{addr_q[0]}};
        endcase
    end

    // Ranges must cover whole bursts so every burst ends exactly on addr_last.
    assign cfg_bad  = (addr_first > addr_last)
                   || ((addr_first & BURST_MASK) != '0)
                   || ((addr_last & BURST_MASK) != BURST_MASK);
    assign mismatch = (data_read != pat_value);
    assign err_inc  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        first_d     = first_q;
        last_d      = last_q;
        pattern_d   = pattern_q;
        lfsr_d      = lfsr_q;
        beat_d      = beat_q;
        end_d       = end_q;
        cfg_err_d   = cfg_err_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pattern_d = pattern;
                    first_d   = addr_first;
                    last_d    = addr_last;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cfg_err_d   = 1'b0;
                        err_cnt_d   = '0;
                        fail_addr_d = '0;
                        fail_exp_d  = '0;
                        fail_act_d  = '0;
                        addr_d      = addr_first;
                        lfsr_d      = LFSR_SEED;
                        beat_d      = BEAT_LOAD;
                        state_d     = S_WR_CMD;
                    end
                end
            end
            S_WR_CMD: begin
                if (data_write_done) begin
                    addr_d = addr_q + ADDR_ONE;
                    lfsr_d = lfsr_next;
                    if (beat_q == 4'd0) begin
                        end_d   = (addr_q == last_q);
                        state_d = S_WR_GAP;
                    end else begin
                        beat_d = beat_q - 4'd1;
                    end
                end
            end
            S_WR_GAP: begin
                beat_d = BEAT_LOAD;
                if (end_q) begin
                    addr_d  = first_q;
                    lfsr_d  = LFSR_SEED;
                    state_d = S_RD_CMD;
                end else begin
                    state_d = S_WR_CMD;
                end
            end
            S_RD_CMD: begin
                if (data_read_valid) begin
                    if (mismatch) begin
                        err_cnt_d = err_inc;
                        if (err_cnt_q == '0) begin
                            fail_addr_d = addr_q;
                            fail_exp_d  = pat_value;
                            fail_act_d  = data_read;
                        end
                    end
                    addr_d = addr_q + ADDR_ONE;
                    lfsr_d = lfsr_next;
                    if (mismatch && (STOP_ON_ERROR != 0)) begin
                        state_d = S_DONE;
                    end else if (beat_q == 4'd0) begin
                        end_d   = (addr_q == last_q);
                        state_d = S_RD_GAP;
                    end else begin
                        beat_d = beat_q - 4'd1;
                    end
                end
            end
            S_RD_GAP: begin
                beat_d  = BEAT_LOAD;
                state_d = end_q ? S_DONE : S_RD_CMD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        command = 2'd0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_WR_CMD: begin command = 2'd1; busy = 1'b1; end
            S_RD_CMD: begin command = 2'd2; busy = 1'b1; end
            S_WR_GAP, S_RD_GAP: busy = 1'b1;
            S_DONE:   done = 1'b1;
            default:  command = 2'd0;
        endcase
    end

    assign data_address  = addr_q;
    assign data_write    = (state_q == S_WR_CMD) ? pat_value : '0;
    assign config_error  = cfg_err_q;
    assign error_count   = err_cnt_q;
    assign fail_address  = fail_addr_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            first_q     <= '0;
            last_q      <= '0;
            pattern_q   <= '0;
            lfsr_q      <= '0;
            beat_q      <= '0;
            end_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            first_q     <= first_d;
            last_q      <= last_d;
            pattern_q   <= pattern_d;
            lfsr_q      <= lfsr_d;
            beat_q      <= beat_d;
            end_q       <= end_d;
            cfg_err_q   <= cfg_err_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: three instances (BL=1, BL=4, BL=1 stop-on-error) each driven
// by a small controller model; expected beats and run results are queued and checked by a monitor.
module tb_sdram_pattern_tester;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic          start   [NI];
    logic [1:0]    pattern [NI];
    logic [AW-1:0] af      [NI];
    logic [AW-1:0] al      [NI];
    logic [1:0]    cmd     [NI];
    logic [AW-1:0] daddr   [NI];
    logic [DW-1:0] dwr     [NI];
    logic [DW-1:0] drd     [NI];
    logic          drv     [NI];
    logic          dwd     [NI];
    logic          busy    [NI];
    logic          done    [NI];
    logic          cerr    [NI];
    logic [31:0]   ecnt    [NI];
    logic [AW-1:0] faddr   [NI];
    logic [DW-1:0] fexp    [NI];
    logic [DW-1:0] fact    [NI];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            sdram_pattern_tester #(
                .ADDR_WIDTH   (AW),
                .DATA_WIDTH   (DW),
                .BURST_LENGTH ((g == 1) ? 4 : 1),
                .STOP_ON_ERROR((g == 2) ? 1 : 0)
            ) u_dut (
                .clk            (clk),
                .resetn         (resetn),
                .start          (start[g]),
                .pattern        (pattern[g]),
                .addr_first     (af[g]),
                .addr_last      (al[g]),
                .command        (cmd[g]),
                .data_address   (daddr[g]),
                .data_write     (dwr[g]),
                .data_read      (drd[g]),
                .data_read_valid(drv[g]),
                .data_write_done(dwd[g]),
                .busy           (busy[g]),
                .done           (done[g]),
                .config_error   (cerr[g]),
                .error_count    (ecnt[g]),
                .fail_address   (faddr[g]),
                .fail_expected  (fexp[g]),
                .fail_actual    (fact[g])
            );
        end
    endgenerate

    // Controller model: one strobe roughly two cycles after each command beat; bit 3 flipped on reads of marked addresses.
    logic [DW-1:0] mem     [NI][64];
    logic [1:0]    lat     [NI];
    logic [63:0]   corrupt [NI];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int g = 0; g < NI; g++) begin
                dwd[g] <= 1'b0;
                drv[g] <= 1'b0;
                drd[g] <= '0;
                lat[g] <= 2'd0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                dwd[g] <= 1'b0;
                drv[g] <= 1'b0;
                if (cmd[g] == 2'd0 || dwd[g] || drv[g]) begin
                    lat[g] <= 2'd0;
                end else if (lat[g] == 2'd1) begin
                    lat[g] <= 2'd0;
                    if (cmd[g] == 2'd1) begin
                        dwd[g] <= 1'b1;
                        mem[g][daddr[g]] <= dwr[g];
                    end else begin
                        drv[g] <= 1'b1;
                        drd[g] <= mem[g][daddr[g]] ^ (corrupt[g][daddr[g]] ? 16'h0008 : 16'h0000);
                    end
                end else begin
                    lat[g] <= lat[g] + 2'd1;
                end
            end
        end
    end

    typedef struct {
        int            inst;
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            inst;
        logic          cerr;
        logic [31:0]   ecnt;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fexp;
        logic [DW-1:0] fact;
        logic          cmd_seen;
    } res_t;

    beat_t bq[$];
    res_t  rq[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    int         cmd_cycles [NI] = '{default: 0};
    logic       done_prev  [NI] = '{default: 1'b0};
    int         hs1 = 0;
    int         gap1 = 0;
    logic [1:0] prev_cmd1 = 2'd0;
    logic       burst_seen1 = 1'b0;

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (start[g]) begin
                cmd_cycles[g] = 0;
                if (g == 1) begin
                    hs1 = 0;
                    gap1 = 0;
                    burst_seen1 = 1'b0;
                end
            end
            if (cmd[g] != 2'd0) cmd_cycles[g]++;
            if ((cmd[g] == 2'd1 && dwd[g]) || (cmd[g] == 2'd2 && drv[g])) begin : beat_chk
                beat_t e;
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: inst %0d cmd %0d addr %0h, none expected", g, cmd[g], daddr[g]);
                end else begin
                    e = bq.pop_front();
                    chk("beat_inst", 32'(g), 32'(e.inst));
                    chk("beat_kind", 32'(cmd[g]), 32'(e.kind));
                    chk("beat_addr", 32'(daddr[g]), 32'(e.addr));
                    if (e.kind == 2'd1) chk("write_data", 32'(dwr[g]), 32'(e.data));
                end
            end
            if (done[g] && !done_prev[g]) begin : res_chk
                res_t r;
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_unexpected: inst %0d done with no expected result", g);
                end else begin
                    r = rq.pop_front();
                    chk("res_inst", 32'(g), 32'(r.inst));
                    chk("config_error", 32'(cerr[g]), 32'(r.cerr));
                    chk("error_count", ecnt[g], r.ecnt);
                    chk("fail_address", 32'(faddr[g]), 32'(r.faddr));
                    chk("fail_expected", 32'(fexp[g]), 32'(r.fexp));
                    chk("fail_actual", 32'(fact[g]), 32'(r.fact));
                    chk("busy_at_done", 32'(busy[g]), 32'd0);
                    chk("command_at_done", 32'(cmd[g]), 32'd0);
                    chk("command_seen", 32'(cmd_cycles[g] != 0), 32'(r.cmd_seen));
                end
            end
            done_prev[g] = done[g];
        end
        if (prev_cmd1 == 2'd1 && cmd[1] != 2'd1) begin
            chk("burst_handshakes", 32'(hs1), 32'd4);
            hs1 = 0;
        end
        if (cmd[1] == 2'd1 && dwd[1]) hs1++;
        if (cmd[1] == 2'd0) begin
            if (busy[1]) gap1++;
        end else begin
            if (prev_cmd1 == 2'd0 && burst_seen1) chk("burst_gap", 32'(gap1), 32'd1);
            gap1 = 0;
            burst_seen1 = 1'b1;
        end
        prev_cmd1 = cmd[1];
    end

    // Stimulus helpers
    task automatic push_w(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bq.push_back('{inst: g, kind: 2'd1, addr: a, data: d});
    endtask

    task automatic push_r(input int g, input logic [AW-1:0] a);
        bq.push_back('{inst: g, kind: 2'd2, addr: a, data: '0});
    endtask

    task automatic push_res(input int g, input logic ce, input logic [31:0] ec, input logic [AW-1:0] fa,
                            input logic [DW-1:0] fe, input logic [DW-1:0] fc, input logic seen);
        rq.push_back('{inst: g, cerr: ce, ecnt: ec, faddr: fa, fexp: fe, fact: fc, cmd_seen: seen});
    endtask

    task automatic launch(input int g, input logic [1:0] p, input logic [AW-1:0] f, input logic [AW-1:0] l);
        pattern[g] = p;
        af[g] = f;
        al[g] = l;
        @(posedge clk);
        #1 start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (rq.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: run did not finish within %0d cycles", name, n);
            rq.delete();
        end
        #2 chk({name, "_beats_left"}, 32'(bq.size()), 32'd0);
        bq.delete();
    endtask

    task automatic check_zero(input int g);
        chk($sformatf("rst%0d_command", g), 32'(cmd[g]), 32'd0);
        chk($sformatf("rst%0d_data_address", g), 32'(daddr[g]), 32'd0);
        chk($sformatf("rst%0d_data_write", g), 32'(dwr[g]), 32'd0);
        chk($sformatf("rst%0d_busy", g), 32'(busy[g]), 32'd0);
        chk($sformatf("rst%0d_done", g), 32'(done[g]), 32'd0);
        chk($sformatf("rst%0d_config_error", g), 32'(cerr[g]), 32'd0);
        chk($sformatf("rst%0d_error_count", g), ecnt[g], 32'd0);
        chk($sformatf("rst%0d_fail_address", g), 32'(faddr[g]), 32'd0);
        chk($sformatf("rst%0d_fail_expected", g), 32'(fexp[g]), 32'd0);
        chk($sformatf("rst%0d_fail_actual", g), 32'(fact[g]), 32'd0);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    initial begin
        logic [15:0] s;
        int n;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0;
            pattern[g] = 2'd0;
            af[g] = '0;
            al[g] = '0;
            corrupt[g] = '0;
        end
        #3 resetn = 1'b0;
        #1 for (int g = 0; g < NI; g++) check_zero(g);
        #8 resetn = 1'b1;

        // Address pattern over the full 6-bit range
        for (int a = 0; a < 64; a++) push_w(0, AW'(a), DW'(a));
        for (int a = 0; a < 64; a++) push_r(0, AW'(a));
        push_res(0, 1'b0, 32'd0, '0, '0, '0, 1'b1);
        launch(0, 2'd0, 6'd0, 6'd63);
        wait_result("addr_pattern");

        // Checkerboard at the top of the address space (addr_last = all ones)
        push_w(0, 6'd60, 16'hAAAA);
        push_w(0, 6'd61, 16'h5555);
        push_w(0, 6'd62, 16'hAAAA);
        push_w(0, 6'd63, 16'h5555);
        for (int a = 60; a < 64; a++) push_r(0, AW'(a));
        push_res(0, 1'b0, 32'd0, '0, '0, '0, 1'b1);
        launch(0, 2'd3, 6'd60, 6'd63);
        wait_result("checker_top");

        // Inverted address with bit 3 corrupted at 0x15
        corrupt[0][21] = 1'b1;
        for (int a = 0; a < 64; a++) push_w(0, AW'(a), DW'(a) ^ 16'hFFFF);
        for (int a = 0; a < 64; a++) push_r(0, AW'(a));
        push_res(0, 1'b0, 32'd1, 6'h15, 16'hFFEA, 16'hFFE2, 1'b1);
        launch(0, 2'd1, 6'd0, 6'd63);
        wait_result("inv_corrupt");
        corrupt[0] = '0;

        // Misaligned range with BURST_LENGTH=4 is rejected
        push_res(1, 1'b1, 32'd0, '0, '0, '0, 1'b0);
        launch(1, 2'd0, 6'd3, 6'd10);
        wait_result("config_err");

        // LFSR bursts of 4 over 8..23
        s = 16'hACE1;
        for (int a = 8; a < 24; a++) begin
            push_w(1, AW'(a), s);
            s = lfsr_step(s);
        end
        for (int a = 8; a < 24; a++) push_r(1, AW'(a));
        push_res(1, 1'b0, 32'd0, '0, '0, '0, 1'b1);
        launch(1, 2'd2, 6'd8, 6'd23);
        wait_result("lfsr_burst");

        // Stop on first error: corruptions at 5 and 9, run ends after comparing 5
        corrupt[2][5] = 1'b1;
        corrupt[2][9] = 1'b1;
        for (int a = 0; a < 16; a++) push_w(2, AW'(a), DW'(a));
        for (int a = 0; a < 6; a++) push_r(2, AW'(a));
        push_res(2, 1'b0, 32'd1, 6'd5, 16'h0005, 16'h000D, 1'b1);
        launch(2, 2'd0, 6'd0, 6'd15);
        wait_result("stop_on_err");
        corrupt[2] = '0;

        // Single-word range
        push_w(2, 6'd7, 16'h0007);
        push_r(2, 6'd7);
        push_res(2, 1'b0, 32'd0, '0, '0, '0, 1'b1);
        launch(2, 2'd0, 6'd7, 6'd7);
        wait_result("single_word");

        // Reset mid-write, then restart
        for (int a = 0; a < 64; a++) push_w(0, AW'(a), DW'(a));
        for (int a = 0; a < 64; a++) push_r(0, AW'(a));
        push_res(0, 1'b0, 32'd0, '0, '0, '0, 1'b1);
        launch(0, 2'd0, 6'd0, 6'd63);
        n = 0;
        while (!(daddr[0] == 6'd5 && cmd[0] == 2'd1) && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("reach_mid_write", 32'(daddr[0] == 6'd5 && cmd[0] == 2'd1), 32'd1);
        #2 resetn = 1'b0;
        #1 check_zero(0);
        bq.delete();
        rq.delete();
        @(posedge clk);
        #2 resetn = 1'b1;
        for (int a = 0; a < 64; a++) push_w(0, AW'(a), DW'(a));
        for (int a = 0; a < 64; a++) push_r(0, AW'(a));
        push_res(0, 1'b0, 32'd0, '0, '0, '0, 1'b1);
        launch(0, 2'd0, 6'd0, 6'd63);
        wait_result("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
